rr_mux_sel_arb: RTL and testbench
=================================

Name: rr_mux_sel_arb

Overview:
- Round-robin arbiter that generates the select vector for a downstream N-way mux stage.
- Collects per-source requests and issues a registered one-hot grant, used directly as the mux select.
- Holds each grant stable until the consumer acknowledges the transfer.
- Grant is always one-hot or all-zero, so the mux select invariant holds by construction.

Parameters:
N, 4, number of requesting sources / mux inputs; N >= 1.
W, $clog2(N) (min 1), width of the encoded grant index.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
i_req  input  N  per-source request; bit k set means source k has data for the mux.
i_ack  input  1  downstream accepted the currently selected source this cycle.
o_gnt  output  N  registered one-hot-or-zero grant; drives the mux select.
o_gnt_vld  output  1  high when o_gnt is non-zero.
o_gnt_enc  output  W  binary index of the granted source; 0 when o_gnt_vld is low.

Behaviour:
- Reset values:
  - o_gnt = 0, o_gnt_vld = 0, o_gnt_enc = 0.
  - Priority pointer = N-1, so source 0 has top priority on the first arbitration.
  - FSM = IDLE.
- FSM states: IDLE (no grant outstanding) and GNT (grant outstanding).
- IDLE:
  - If |i_req, select the lowest index strictly after the pointer, wrapping modulo N.
  - Register the selection into o_gnt and go to GNT.
  - Latency: request at cycle t gives the grant at t+1.
  - If no request, stay in IDLE with all outputs 0.
- GNT, i_ack=1:
  - Pointer is set to the granted index.
  - Re-arbitrate the same cycle over i_req, with the just-served bit masked for this cycle only.
  - If another request is pending, o_gnt switches directly to the new winner at the next edge (no bubble).
  - Otherwise go to IDLE with o_gnt = 0.
  - If the served source is the only requester and still requesting, it is granted again after one IDLE cycle.
- GNT, i_ack=0, granted i_req bit still high: o_gnt, o_gnt_enc and the pointer are all held.
- GNT, granted i_req bit drops without ack (withdrawal):
  - Next cycle o_gnt = 0, FSM = IDLE, pointer unchanged.
  - Withdrawal takes precedence only when i_ack=0.
- i_ack while in IDLE: ignored; no state change.
- Changes to other requesters' bits during GNT: no effect until the grant ends.
- o_gnt never changes while o_gnt_vld=1 unless i_ack=1 or the granted request was withdrawn on the previous cycle.
- rst asserted in any state, including mid-grant: at the next edge all outputs and the pointer return to reset values, and any in-flight ack is discarded.
- N=1: o_gnt = registered i_req gated by the FSM; o_gnt_enc is tied to 0.
- Invariant: $onehot0(o_gnt) every cycle; o_gnt_vld == |o_gnt.

Optional Feature:
- Macro: RR_MUX_SEL_ARB_LOCK_EN.
- When defined:
  - Adds input port i_last (1 bit).
  - A grant is released only on a cycle with i_ack && i_last.
  - i_ack without i_last keeps o_gnt held and leaves the pointer unchanged, giving multi-beat packet lock.
  - Withdrawal still releases the grant.
- When undefined:
  - No i_last port.
  - Every i_ack ends the grant as described in Behaviour.

Test Plan:
1. Reset: rst=1 for 3 cycles with i_req=4'b1111 -> o_gnt=0 and o_gnt_vld=0 throughout; first cycle after rst falls o_gnt=0, next cycle o_gnt=4'b0001, o_gnt_enc=0.
2. Fairness: i_req=4'b1111 held, i_ack=1 on every grant cycle -> o_gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no zero cycles.
3. Hold: i_req=4'b0101, i_ack low for 5 cycles after the grant -> o_gnt=0001 stable for 5 cycles; ack on cycle 6 -> o_gnt=0100 the next cycle.
4. Withdrawal: from reset, i_req=4'b0010 -> o_gnt=0010. Drop bit 1 before ack -> o_gnt=0 next cycle. Then i_req=4'b0110 -> o_gnt=0010 again, since the pointer was unchanged.
5. Reset mid-grant: o_gnt=0100 outstanding, assert rst together with i_ack=1 -> o_gnt=0 next cycle; after release with i_req=4'b1100 -> o_gnt=0100 (pointer back to N-1).
6. Lock (RR_MUX_SEL_ARB_LOCK_EN): i_req=4'b0011, three acks with i_last=0,0,1 -> o_gnt=0001 held through all three acks, 0010 on the cycle after the i_last ack.

Source files
------------

// File: rtl/rr_mux_sel_arb.sv
// rtl/rr_mux_sel_arb.sv - round-robin arbiter producing a registered one-hot mux select
//
// Purpose:
//   Arbitrates N request lines round-robin and issues a registered one-hot
//   grant that directly drives a downstream N-way mux select. A grant is held
//   until the consumer acknowledges the transfer or the granted source
//   withdraws its request.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   i_req      - [N-1:0] per-source request
//   i_ack      - downstream accepted the selected source this cycle
//   i_last     - (RR_MUX_SEL_ARB_LOCK_EN only) ack closes the packet
//   o_gnt      - [N-1:0] registered one-hot-or-zero grant (mux select)
//   o_gnt_vld  - o_gnt is non-zero
//   o_gnt_enc  - [W-1:0] binary index of granted source, 0 when idle
//
// Configuration:
//   RR_MUX_SEL_ARB_LOCK_EN - when defined, adds i_last; a grant is released
//   only by i_ack && i_last (multi-beat packet lock).

module rr_mux_sel_arb #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_ack,
`ifdef RR_MUX_SEL_ARB_LOCK_EN
    input  logic         i_last,
`endif
    output logic [N-1:0] o_gnt,
    output logic         o_gnt_vld,
    output logic [W-1:0] o_gnt_enc
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    // Pointer resets to the last source so source 0 wins the first arbitration.
    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   enc_q, enc_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic           release_ack;
    logic           granted_req;
    logic [N-1:0]   pick_idle;
    logic [N-1:0]   pick_next;

    // Lowest-index requester strictly after ptr, wrapping modulo N.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [W-1:0] ptr);
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] onehot_enc(input logic [N-1:0] g);
        logic [W-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                e = e | W'(i);
            end
        end
        return e;
    endfunction

`ifdef RR_MUX_SEL_ARB_LOCK_EN
    assign release_ack = i_ack & i_last;
`else
    assign release_ack = i_ack;
`endif

    assign granted_req = |(i_req & gnt_q);

    assign pick_idle = rr_pick(i_req, ptr_q);
    // Re-arbitration on ack: served source masked for this cycle only, and
    // the search starts after the served index (the new pointer).
    assign pick_next = rr_pick(i_req & ~gnt_q, enc_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        enc_d   = enc_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                // i_ack is ignored here; nothing is outstanding.
                if (|i_req) begin
                    state_d = ST_GNT;
                    gnt_d   = pick_idle;
                    enc_d   = onehot_enc(pick_idle);
                end else begin
                    gnt_d = '0;
                    enc_d = '0;
                end
            end
            ST_GNT: begin
                if (release_ack) begin
                    ptr_d = enc_q;
                    if (|pick_next) begin
                        gnt_d = pick_next;
                        enc_d = onehot_enc(pick_next);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        enc_d   = '0;
                    end
                end else if (!granted_req) begin
                    // Withdrawal: drop the grant, pointer untouched.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    enc_d   = '0;
                end
                // Otherwise hold grant and pointer (incl. locked mid-packet acks).
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                enc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            enc_q   <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            enc_q   <= enc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = |gnt_q;

    generate
        if (N == 1) begin : g_enc_single
            assign o_gnt_enc = '0;
        end else begin : g_enc_multi
            assign o_gnt_enc = enc_q;
        end
    endgenerate

endmodule

// File: tb/tb_rr_mux_sel_arb.sv
// tb/tb_rr_mux_sel_arb.sv - directed self-checking bench for rr_mux_sel_arb

module tb_rr_mux_sel_arb;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] i_req;
    logic         i_ack;
    logic         i_last;
    logic [N-1:0] o_gnt;
    logic         o_gnt_vld;
    logic [W-1:0] o_gnt_enc;

    int n_cmp;
    int n_err;

    rr_mux_sel_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_ack     (i_ack),
`ifdef RR_MUX_SEL_ARB_LOCK_EN
        .i_last    (i_last),
`endif
        .o_gnt     (o_gnt),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt_enc (o_gnt_enc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check the invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        check_eq("onehot0", 32'($onehot0(o_gnt)), 32'd1);
        check_eq("vld_eq_or", 32'(o_gnt_vld), 32'(|o_gnt));
    endtask

    task automatic expect_gnt(input string tag, input logic [N-1:0] g, input logic [W-1:0] e);
        check_eq(tag, 32'(o_gnt), 32'(g));
        check_eq({tag, "_enc"}, 32'(o_gnt_enc), 32'(e));
        check_eq({tag, "_vld"}, 32'(o_gnt_vld), 32'(|g));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_ack = 1'b0;
        i_req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        i_req  = 4'b1111;
        i_ack  = 1'b0;
        i_last = 1'b1;

        // 1. Reset held 3 cycles with all requests high.
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_gnt("rst_hold", 4'b0000, 2'd0);
        end
        rst = 1'b0;
        expect_gnt("rst_rel0", 4'b0000, 2'd0);
        tick();
        expect_gnt("rst_first", 4'b0001, 2'd0);

        // 2. Fairness: ack every grant, no bubbles.
        i_ack = 1'b1;
        tick(); expect_gnt("rr_1", 4'b0010, 2'd1);
        tick(); expect_gnt("rr_2", 4'b0100, 2'd2);
        tick(); expect_gnt("rr_3", 4'b1000, 2'd3);
        tick(); expect_gnt("rr_wrap", 4'b0001, 2'd0);
        i_ack = 1'b0;

        // 3. Hold without ack, then ack moves to source 2.
        do_reset();
        i_req = 4'b0101;
        tick(); expect_gnt("hold_g", 4'b0001, 2'd0);
        for (int c = 0; c < 5; c++) begin
            tick(); expect_gnt("hold", 4'b0001, 2'd0);
        end
        i_ack = 1'b1;
        tick(); expect_gnt("hold_ack", 4'b0100, 2'd2);
        i_ack = 1'b0;

        // 4. Withdrawal leaves pointer alone; idle ack is ignored.
        do_reset();
        i_req = 4'b0010;
        tick(); expect_gnt("wd_g", 4'b0010, 2'd1);
        i_req = 4'b0000;
        tick(); expect_gnt("wd_drop", 4'b0000, 2'd0);
        i_ack = 1'b1;
        tick(); expect_gnt("idle_ack", 4'b0000, 2'd0);
        i_ack = 1'b0;
        i_req = 4'b0110;
        tick(); expect_gnt("wd_regnt", 4'b0010, 2'd1);

        // 5. Reset mid-grant discards the ack and restores the pointer.
        do_reset();
        i_req = 4'b0100;
        tick(); expect_gnt("mid_g", 4'b0100, 2'd2);
        rst   = 1'b1;
        i_ack = 1'b1;
        tick(); expect_gnt("mid_rst", 4'b0000, 2'd0);
        rst   = 1'b0;
        i_ack = 1'b0;
        i_req = 4'b1100;
        tick(); expect_gnt("mid_after", 4'b0100, 2'd2);

        // Sole requester re-granted after one idle cycle; others ignored while held.
        do_reset();
        i_req = 4'b0001;
        tick(); expect_gnt("solo_g", 4'b0001, 2'd0);
        i_req = 4'b1111;
        tick(); expect_gnt("others", 4'b0001, 2'd0);
        i_req = 4'b0001;
        i_ack = 1'b1;
        tick(); expect_gnt("solo_idle", 4'b0000, 2'd0);
        i_ack = 1'b0;
        tick(); expect_gnt("solo_again", 4'b0001, 2'd0);

`ifdef RR_MUX_SEL_ARB_LOCK_EN
        // 6. Packet lock: only ack with i_last releases.
        do_reset();
        i_req = 4'b0011;
        tick(); expect_gnt("lock_g", 4'b0001, 2'd0);
        i_ack  = 1'b1;
        i_last = 1'b0;
        tick(); expect_gnt("lock_b0", 4'b0001, 2'd0);
        tick(); expect_gnt("lock_b1", 4'b0001, 2'd0);
        i_last = 1'b1;
        tick(); expect_gnt("lock_rel", 4'b0010, 2'd1);
        i_ack = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
